// File: rtl/plab4_net_domain_outq.sv
// Domain-tagged output queue: circular FIFO feeding a two-domain demux. A
// message whose tag differs from the current domain costs one bubble cycle.
module plab4_net_domain_outq #(
  parameter int p_msg_cnbits  = 32,
  parameter int p_msg_dnbits  = 32,
  parameter int p_num_entries = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_val,
  output logic                            in_rdy,
  input  logic                            in_domain,
  input  logic [p_msg_cnbits-1:0]         in_msg_control,
  input  logic [p_msg_dnbits-1:0]         in_msg_data,
  output logic                            out_val,
  input  logic                            out_rdy,
  output logic                            domain,
  output logic [p_msg_cnbits-1:0]         out_msg_control,
  output logic [p_msg_dnbits-1:0]         out_msg_data,
  output logic [$clog2(p_num_entries):0]  num_free
);
  localparam int AW = $clog2(p_num_entries);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] NE  = CW'(p_num_entries);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef struct packed {
    logic                    dom;
    logic [p_msg_cnbits-1:0] ctrl;
    logic [p_msg_dnbits-1:0] data;
  } entry_t;

  typedef enum logic {SEND, SWITCH} state_t;

  entry_t          mem [p_num_entries];
  entry_t          head;
  logic [AW-1:0]   enq_ptr, deq_ptr, deq_nxt;
  logic [CW-1:0]   count, nxt_cnt;
  logic            last_domain, nxt_last, nxt_tag;
  logic            enq, deq, empty;
  state_t          state, nxt_state;

  assign head            = mem[deq_ptr];
  assign deq_nxt         = deq_ptr + 1'b1;
  assign empty           = (count == '0);
  assign in_rdy          = (count != NE);
  assign enq             = in_val && in_rdy;
  assign deq             = out_val && out_rdy;
  assign domain          = last_domain;
  assign out_msg_control = head.ctrl;
  assign out_msg_data    = head.data;
  assign num_free        = NE - count;

  always_comb begin
    nxt_cnt = count;
    case ({enq, deq})
      2'b10:   nxt_cnt = count + ONE;
      2'b01:   nxt_cnt = count - ONE;
      default: nxt_cnt = count;
    endcase
  end

  // Look one edge ahead at the head tag so the switch cycle lines up with the
  // first cycle the mismatched message sits at the head: one bubble, no more.
  always_comb begin
    nxt_tag = head.dom;
    if (deq)
      nxt_tag = (count == ONE) ? in_domain : mem[deq_nxt].dom;
    else if (empty)
      nxt_tag = in_domain;
  end

  always_comb begin
    out_val   = 1'b0;
    nxt_state = state;
    nxt_last  = last_domain;
    case (state)
      SEND: begin
        out_val = !empty && (head.dom == last_domain);
        if (nxt_cnt != '0 && nxt_tag != last_domain) nxt_state = SWITCH;
      end
      SWITCH: begin
        nxt_last  = head.dom;
        nxt_state = SEND;
      end
      default: nxt_state = SEND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      enq_ptr     <= '0;
      deq_ptr     <= '0;
      count       <= '0;
      last_domain <= 1'b0;
      state       <= SEND;
    end else begin
      if (enq) enq_ptr <= enq_ptr + 1'b1;
      if (deq) deq_ptr <= deq_nxt;
      count       <= nxt_cnt;
      last_domain <= nxt_last;
      state       <= nxt_state;
    end
  end

  // Entry storage is not reset; a write is suppressed while reset is low.
  always_ff @(posedge clk) begin
    if (reset && enq) mem[enq_ptr] <= '{dom: in_domain, ctrl: in_msg_control, data: in_msg_data};
  end
endmodule

// File: tb/tb_plab4_net_domain_outq.sv
module tb_plab4_net_domain_outq;
  logic        clk = 1'b0;
  logic        reset, in_val, in_rdy, in_domain, out_val, out_rdy, domain;
  logic [31:0] in_msg_control, in_msg_data, out_msg_control, out_msg_data;
  logic [2:0]  num_free;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  plab4_net_domain_outq #(.p_msg_cnbits(32), .p_msg_dnbits(32), .p_num_entries(4)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_domain(in_domain),
    .in_msg_control(in_msg_control), .in_msg_data(in_msg_data), .out_val(out_val),
    .out_rdy(out_rdy), .domain(domain), .out_msg_control(out_msg_control),
    .out_msg_data(out_msg_data), .num_free(num_free)
  );

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic tag, input logic [31:0] c, input logic [31:0] d);
    in_val = 1'b1; in_domain = tag; in_msg_control = c; in_msg_data = d;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
    tick();
    tick();
    chk("rst_out_val", out_val === 1'b0, out_val, 1'b0);
    chk("rst_in_rdy", in_rdy === 1'b1, in_rdy, 1'b1);
    chk("rst_domain", domain === 1'b0, domain, 1'b0);
    chk("rst_num_free", num_free === 3'd4, num_free, 3'd4);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; in_val = 1'b0; in_domain = 1'b0; out_rdy = 1'b0;
    in_msg_control = '0; in_msg_data = '0;
    do_reset();

    push(1'b0, 32'h11, 32'hAA); out_rdy = 1'b1;
    tick();
    in_val = 1'b0;
    chk("s1_out_val", out_val === 1'b1, out_val, 1'b1);
    chk("s1_domain", domain === 1'b0, domain, 1'b0);
    chk("s1_ctrl", out_msg_control === 32'h11, out_msg_control, 32'h11);
    chk("s1_data", out_msg_data === 32'hAA, out_msg_data, 32'hAA);
    chk("s1_num_free", num_free === 3'd3, num_free, 3'd3);
    tick();
    chk("s1_drained", out_val === 1'b0, out_val, 1'b0);
    chk("s1_num_free_end", num_free === 3'd4, num_free, 3'd4);

    push(1'b0, 32'h01, 32'h0);
    tick();
    push(1'b1, 32'h02, 32'h0);
    chk("s2_first_val", out_val === 1'b1, out_val, 1'b1);
    chk("s2_first_ctrl", out_msg_control === 32'h01, out_msg_control, 32'h01);
    chk("s2_first_dom", domain === 1'b0, domain, 1'b0);
    tick();
    in_val = 1'b0;
    chk("s2_bubble_val", out_val === 1'b0, out_val, 1'b0);
    chk("s2_bubble_dom", domain === 1'b0, domain, 1'b0);
    tick();
    chk("s2_second_val", out_val === 1'b1, out_val, 1'b1);
    chk("s2_second_dom", domain === 1'b1, domain, 1'b1);
    chk("s2_second_ctrl", out_msg_control === 32'h02, out_msg_control, 32'h02);
    tick();
    chk("s2_drained", out_val === 1'b0, out_val, 1'b0);

    do_reset();
    push(1'b1, 32'h33, 32'h0); out_rdy = 1'b1;
    tick();
    in_val = 1'b0;
    chk("s3_switch_val", out_val === 1'b0, out_val, 1'b0);
    chk("s3_switch_dom", domain === 1'b0, domain, 1'b0);
    tick();
    chk("s3_val", out_val === 1'b1, out_val, 1'b1);
    chk("s3_dom", domain === 1'b1, domain, 1'b1);
    chk("s3_ctrl", out_msg_control === 32'h33, out_msg_control, 32'h33);
    tick();
    chk("s3_drained", out_val === 1'b0, out_val, 1'b0);
    chk("s3_num_free", num_free === 3'd4, num_free, 3'd4);

    out_rdy = 1'b0;
    push(1'b1, 32'h70, 32'h0);
    tick();
    for (int i = 1; i < 4; i++) begin
      push(1'b0, 32'h70 + i, 32'h0);
      tick();
    end
    in_val = 1'b0; out_rdy = 1'b1;
    chk("s6_full", num_free === 3'd0, num_free, 3'd0);
    chk("s6_head_ctrl", out_msg_control === 32'h70, out_msg_control, 32'h70);
    chk("s6_head_dom", domain === 1'b1, domain, 1'b1);
    tick();
    chk("s6_switch_val", out_val === 1'b0, out_val, 1'b0);
    chk("s6_switch_dom", domain === 1'b1, domain, 1'b1);
    chk("s6_switch_free", num_free === 3'd1, num_free, 3'd1);
    reset = 1'b0;
    push(1'b0, 32'h7F, 32'h0);
    tick();
    chk("s6_rst_val", out_val === 1'b0, out_val, 1'b0);
    chk("s6_rst_free", num_free === 3'd4, num_free, 3'd4);
    chk("s6_rst_dom", domain === 1'b0, domain, 1'b0);
    chk("s6_rst_rdy", in_rdy === 1'b1, in_rdy, 1'b1);
    reset = 1'b1; in_val = 1'b0;
    tick();
    tick();
    chk("s6_no_stale_val", out_val === 1'b0, out_val, 1'b0);
    chk("s6_no_stale_free", num_free === 3'd4, num_free, 3'd4);

    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 32'h20 + i, 32'h0);
      tick();
      chk("s4_fill_free", num_free === 3'(3 - i), num_free, 3'(3 - i));
    end
    chk("s4_full_rdy", in_rdy === 1'b0, in_rdy, 1'b0);
    chk("s4_full_val", out_val === 1'b1, out_val, 1'b1);
    push(1'b0, 32'h24, 32'h0);
    tick();
    chk("s4_held_free", num_free === 3'd0, num_free, 3'd0);
    chk("s4_held_head", out_msg_control === 32'h20, out_msg_control, 32'h20);
    out_rdy = 1'b1;
    tick();
    chk("s4_rdy_back", in_rdy === 1'b1, in_rdy, 1'b1);
    chk("s4_order1", out_msg_control === 32'h21, out_msg_control, 32'h21);
    chk("s4_free1", num_free === 3'd1, num_free, 3'd1);
    tick();
    in_val = 1'b0;
    chk("s4_order2", out_msg_control === 32'h22, out_msg_control, 32'h22);
    chk("s4_free2", num_free === 3'd1, num_free, 3'd1);
    tick();
    chk("s4_order3", out_msg_control === 32'h23, out_msg_control, 32'h23);
    tick();
    chk("s4_order4", out_msg_control === 32'h24, out_msg_control, 32'h24);
    chk("s4_order4_val", out_val === 1'b1, out_val, 1'b1);
    tick();
    chk("s4_drained", out_val === 1'b0, out_val, 1'b0);
    chk("s4_free_end", num_free === 3'd4, num_free, 3'd4);

    out_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push(1'b0, 32'h40 + i, 32'hC000 + i);
      tick();
      chk("s5_val", out_val === 1'b1, out_val, 1'b1);
      chk("s5_ctrl", out_msg_control === 32'h40 + i, out_msg_control, 32'h40 + i);
      chk("s5_data", out_msg_data === 32'hC000 + i, out_msg_data, 32'hC000 + i);
      chk("s5_free", num_free === 3'd3, num_free, 3'd3);
    end
    in_val = 1'b0;
    tick();
    chk("s5_drained", out_val === 1'b0, out_val, 1'b0);
    chk("s5_free_end", num_free === 3'd4, num_free, 3'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
